// File: rtl/arcade_ioctl_pkg.sv
// Shared types and defaults for MiSTer-style ioctl download routing.
package arcade_ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } ioctl_state_e;

    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] MOD_INDEX_DEF = 8'd1;
    localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

    localparam int unsigned NUM_REGIONS_DEF = 4;
    localparam int unsigned ADDR_W_DEF      = 25;

    // Region r occupies slice [r*ADDR_W +: ADDR_W]; bases ascend with r.
    localparam logic [NUM_REGIONS_DEF*ADDR_W_DEF-1:0] REGION_BASE_DEF =
        {25'h30000, 25'h20000, 25'h10000, 25'h00000};

endpackage

// File: rtl/ioctl_region_decode.sv
// Priority decode of a byte address into region number and region-relative offset.
module ioctl_region_decode
    import arcade_ioctl_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = NUM_REGIONS_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned SEL_W       = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = REGION_BASE_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel_c,
    output logic [ADDR_W-1:0] rel_addr_c
);

    // Bases ascend, so the last matching region is the highest one.
    always_comb begin
        sel_c      = '0;
        rel_addr_c = addr - REGION_BASE[ADDR_W-1:0];
        for (int unsigned r = 1; r < NUM_REGIONS; r++) begin
            if (REGION_BASE[r*ADDR_W +: ADDR_W] <= addr) begin
                sel_c      = SEL_W'(r);
                rel_addr_c = addr - REGION_BASE[r*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/arcade_ioctl_router.sv
// Routes HPS ioctl downloads: ROM bytes to region targets with handshake, DIP and MOD bytes to registers.
module arcade_ioctl_router
    import arcade_ioctl_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = NUM_REGIONS_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = REGION_BASE_DEF,
    parameter logic [ADDR_W-1:0] ROM_SIZE = ADDR_W'('h40000),
    parameter int unsigned DIP_BYTES   = 8,
    parameter logic [7:0] ROM_INDEX    = ROM_INDEX_DEF,
    parameter logic [7:0] MOD_INDEX    = MOD_INDEX_DEF,
    parameter logic [7:0] DIP_INDEX    = DIP_INDEX_DEF
) (
    input  logic                     clk_sys,
    input  logic                     RESET_n,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [ADDR_W-1:0]        ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic                     ioctl_wait,
    output logic                     rom_wr,
    output logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] rom_sel,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic [7:0]               rom_data,
    input  logic                     rom_ack,
    output logic [DIP_BYTES*8-1:0]   dip,
    output logic [7:0]               mod_id,
    output logic                     rom_loaded,
    output logic                     done_pulse,
    output logic [ADDR_W-1:0]        byte_count,
    output logic                     err_range,
    output logic                     err_ovf
);

    localparam int unsigned SEL_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned DIP_SEL_W = (DIP_BYTES > 1) ? $clog2(DIP_BYTES) : 1;

    ioctl_state_e      state, state_n;
    logic              dl_q, rom_xfer, xfer_n;
    logic              rom_wr_n, wait_n, done_n, loaded_n, err_range_n, err_ovf_n;
    logic [SEL_W-1:0]  sel_n, dec_sel_c;
    logic [ADDR_W-1:0] addr_n, count_n, dec_rel_c;
    logic [7:0]        data_n;
    logic              rom_idx_c, dl_rise_c, dl_fall_c;
    logic [DIP_SEL_W-1:0] dip_idx_c;

    ioctl_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .SEL_W       (SEL_W),
        .REGION_BASE (REGION_BASE)
    ) u_decode (
        .addr       (ioctl_addr),
        .sel_c      (dec_sel_c),
        .rel_addr_c (dec_rel_c)
    );

    assign rom_idx_c = (ioctl_index == ROM_INDEX);
    assign dl_rise_c = ioctl_download & ~dl_q;
    assign dl_fall_c = ~ioctl_download & dl_q;
    assign dip_idx_c = ioctl_addr[DIP_SEL_W-1:0];

    // Next-state and registered-output logic for the ROM write path.
    always_comb begin
        state_n     = state;
        rom_wr_n    = rom_wr;
        wait_n      = ioctl_wait;
        sel_n       = rom_sel;
        addr_n      = rom_addr;
        data_n      = rom_data;
        done_n      = 1'b0;
        loaded_n    = rom_loaded;
        count_n     = byte_count;
        err_range_n = err_range;
        err_ovf_n   = err_ovf;
        xfer_n      = rom_xfer;

        if (dl_rise_c) begin
            xfer_n = rom_idx_c;
            if (rom_idx_c) begin
                count_n     = '0;
                err_range_n = 1'b0;
                err_ovf_n   = 1'b0;
                loaded_n    = 1'b0;
            end
        end else if (dl_fall_c) begin
            xfer_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (ioctl_wr && ioctl_download && rom_idx_c) begin
                    if (ioctl_addr < ROM_SIZE) begin
                        sel_n    = dec_sel_c;
                        addr_n   = dec_rel_c;
                        data_n   = ioctl_dout;
                        rom_wr_n = 1'b1;
                        wait_n   = 1'b1;
                        state_n  = REQ;
                    end else begin
                        err_range_n = 1'b1;
                    end
                end else if (dl_fall_c && rom_xfer) begin
                    done_n   = 1'b1;
                    loaded_n = 1'b1;
                end
            end
            REQ, FLUSH: begin
                if (ioctl_wr && rom_idx_c) err_ovf_n = 1'b1;
                if (rom_ack) begin
                    rom_wr_n = 1'b0;
                    wait_n   = 1'b0;
                    state_n  = IDLE;
                    if (count_n != '1) count_n = count_n + ADDR_W'(1);
                    // A download that ended while the write was pending finishes here.
                    if (state == FLUSH || dl_fall_c) begin
                        done_n   = 1'b1;
                        loaded_n = 1'b1;
                    end
                end else if (dl_fall_c) begin
                    state_n = FLUSH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            rom_wr     <= 1'b0;
            ioctl_wait <= 1'b0;
            rom_sel    <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            done_pulse <= 1'b0;
            rom_loaded <= 1'b0;
            byte_count <= '0;
            err_range  <= 1'b0;
            err_ovf    <= 1'b0;
            rom_xfer   <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state      <= state_n;
            rom_wr     <= rom_wr_n;
            ioctl_wait <= wait_n;
            rom_sel    <= sel_n;
            rom_addr   <= addr_n;
            rom_data   <= data_n;
            done_pulse <= done_n;
            rom_loaded <= loaded_n;
            byte_count <= count_n;
            err_range  <= err_range_n;
            err_ovf    <= err_ovf_n;
            rom_xfer   <= xfer_n;
            dl_q       <= ioctl_download;
        end
    end

    // DIP and MOD capture run independently of the ROM state machine.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            dip    <= '1;
            mod_id <= '0;
        end else if (ioctl_wr) begin
            if (ioctl_index == DIP_INDEX && ioctl_addr < ADDR_W'(DIP_BYTES))
                dip[32'(dip_idx_c)*8 +: 8] <= ioctl_dout;
            if (ioctl_index == MOD_INDEX)
                mod_id <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_arcade_ioctl_router.sv
// Directed bench for arcade_ioctl_router with hand-computed expectations.
module tb_arcade_ioctl_router;

    logic        clk_sys;
    logic        RESET_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_wr;
    logic [1:0]  rom_sel;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic [63:0] dip;
    logic [7:0]  mod_id;
    logic        rom_loaded;
    logic        done_pulse;
    logic [24:0] byte_count;
    logic        err_range;
    logic        err_ovf;

    int vectors;
    int miscompares;

    arcade_ioctl_router dut (
        .clk_sys        (clk_sys),
        .RESET_n        (RESET_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_wr         (rom_wr),
        .rom_sel        (rom_sel),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_ack        (rom_ack),
        .dip            (dip),
        .mod_id         (mod_id),
        .rom_loaded     (rom_loaded),
        .done_pulse     (done_pulse),
        .byte_count     (byte_count),
        .err_range      (err_range),
        .err_ovf        (err_ovf)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; rom_ack = 1'b0;
        tick(); tick();
        vectors++;
        if ({rom_wr, ioctl_wait, done_pulse, rom_loaded, err_range, err_ovf} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {rom_wr, ioctl_wait, done_pulse, rom_loaded, err_range, err_ovf});
        end
        vectors++;
        if ({dip, mod_id, byte_count} !== {64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 25'h0}) begin
            miscompares++;
            $display("FAIL reset_regs: got dip=%h mod=%h cnt=%h expected ffffffffffffffff/00/0",
                     dip, mod_id, byte_count);
        end
        RESET_n = 1'b1;
        tick();
    endtask

    task automatic test_rom_zero_wait();
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        rom_ack = 1'b1;
        send(8'd0, 25'h10005, 8'hA5);
        vectors++;
        if ({rom_wr, ioctl_wait, rom_sel, rom_addr, rom_data} !== {2'b11, 2'd1, 25'h5, 8'hA5}) begin
            miscompares++;
            $display("FAIL zw_issue: got wr=%b wait=%b sel=%0d addr=%h data=%h expected 1 1 1 5 a5",
                     rom_wr, ioctl_wait, rom_sel, rom_addr, rom_data);
        end
        tick();
        vectors++;
        if ({rom_wr, ioctl_wait, byte_count} !== {2'b00, 25'd1}) begin
            miscompares++;
            $display("FAIL zw_done: got wr=%b wait=%b cnt=%0d expected 0 0 1",
                     rom_wr, ioctl_wait, byte_count);
        end
    endtask

    task automatic test_rom_stall();
        int highs;
        rom_ack = 1'b0;
        send(8'd0, 25'h20010, 8'h3C);
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({rom_wr, ioctl_wait, rom_sel, rom_addr, rom_data} !== {2'b11, 2'd2, 25'h10, 8'h3C}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got wr=%b wait=%b sel=%0d addr=%h data=%h expected 1 1 2 10 3c",
                         i, rom_wr, ioctl_wait, rom_sel, rom_addr, rom_data);
            end
            if (i == 5) break;
            if (i == 2) send(8'd0, 25'h00001, 8'h77);
            else tick();
        end
        vectors++;
        if (err_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ovf: got %b expected 1", err_ovf);
        end
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
        vectors++;
        if ({rom_wr, ioctl_wait, byte_count} !== {2'b00, 25'd2}) begin
            miscompares++;
            $display("FAIL stall_done: got wr=%b wait=%b cnt=%0d expected 0 0 2",
                     rom_wr, ioctl_wait, byte_count);
        end
    endtask

    task automatic test_rom_range();
        send(8'd0, 25'h40000, 8'hEE);
        vectors++;
        if ({rom_wr, ioctl_wait, err_range, byte_count} !== {3'b001, 25'd2}) begin
            miscompares++;
            $display("FAIL range_reject: got wr=%b wait=%b err=%b cnt=%0d expected 0 0 1 2",
                     rom_wr, ioctl_wait, err_range, byte_count);
        end
        ioctl_download = 1'b0;
        tick();
        vectors++;
        if ({done_pulse, rom_loaded} !== 2'b11) begin
            miscompares++;
            $display("FAIL idle_end: got done=%b loaded=%b expected 1 1", done_pulse, rom_loaded);
        end
        tick();
        vectors++;
        if (done_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done_width: got %b expected 0", done_pulse);
        end
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        vectors++;
        if ({err_range, err_ovf, rom_loaded, byte_count} !== {3'b000, 25'd0}) begin
            miscompares++;
            $display("FAIL restart_clear: got er=%b eo=%b loaded=%b cnt=%0d expected 0 0 0 0",
                     err_range, err_ovf, rom_loaded, byte_count);
        end
    endtask

    task automatic test_flush();
        rom_ack = 1'b0;
        send(8'd0, 25'h30002, 8'h5A);
        vectors++;
        if ({rom_wr, rom_sel, rom_addr, rom_data} !== {1'b1, 2'd3, 25'h2, 8'h5A}) begin
            miscompares++;
            $display("FAIL flush_issue: got wr=%b sel=%0d addr=%h data=%h expected 1 3 2 5a",
                     rom_wr, rom_sel, rom_addr, rom_data);
        end
        ioctl_download = 1'b0;
        tick();
        vectors++;
        if ({rom_wr, ioctl_wait, done_pulse} !== 3'b110) begin
            miscompares++;
            $display("FAIL flush_pending: got wr=%b wait=%b done=%b expected 1 1 0",
                     rom_wr, ioctl_wait, done_pulse);
        end
        send(8'd1, 25'h0, 8'h42);
        ioctl_index = 8'd0;
        vectors++;
        if ({mod_id, rom_wr, err_ovf} !== {8'h42, 2'b10}) begin
            miscompares++;
            $display("FAIL flush_mod: got mod=%h wr=%b ovf=%b expected 42 1 0", mod_id, rom_wr, err_ovf);
        end
        tick();
        rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
        vectors++;
        if ({rom_wr, ioctl_wait, done_pulse, rom_loaded, byte_count} !== {4'b0011, 25'd1}) begin
            miscompares++;
            $display("FAIL flush_done: got wr=%b wait=%b done=%b loaded=%b cnt=%0d expected 0 0 1 1 1",
                     rom_wr, ioctl_wait, done_pulse, rom_loaded, byte_count);
        end
        tick();
        vectors++;
        if (done_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_done_width: got %b expected 0", done_pulse);
        end
    endtask

    task automatic test_dip_mod();
        logic [7:0] exp;
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        tick();
        for (int a = 0; a < 10; a++) send(8'd254, 25'(a), 8'(8'h10 + a));
        ioctl_download = 1'b0;
        tick();
        for (int n = 0; n < 8; n++) begin
            exp = 8'(8'h10 + n);
            vectors++;
            if (dip[n*8 +: 8] !== exp) begin
                miscompares++;
                $display("FAIL dip_byte[%0d]: got %h expected %h", n, dip[n*8 +: 8], exp);
            end
        end
        vectors++;
        if ({rom_wr, done_pulse, rom_loaded, byte_count} !== {3'b001, 25'd1}) begin
            miscompares++;
            $display("FAIL dip_isolation: got wr=%b done=%b loaded=%b cnt=%0d expected 0 0 1 1",
                     rom_wr, done_pulse, rom_loaded, byte_count);
        end
        send(8'd1, 25'h0, 8'h01);
        vectors++;
        if (mod_id !== 8'h01) begin
            miscompares++;
            $display("FAIL mod_last: got %h expected 01", mod_id);
        end
    endtask

    task automatic test_reset_mid_req();
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        rom_ack = 1'b0;
        send(8'd0, 25'h0, 8'h11);
        vectors++;
        if (rom_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: got wr=%b expected 1", rom_wr);
        end
        #2 RESET_n = 1'b0;
        #1;
        vectors++;
        if ({rom_wr, ioctl_wait, mod_id, dip} !== {2'b00, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            miscompares++;
            $display("FAIL rst_async: got wr=%b wait=%b mod=%h dip=%h expected 0 0 00 ffffffffffffffff",
                     rom_wr, ioctl_wait, mod_id, dip);
        end
        ioctl_download = 1'b0;
        tick();
        #2 RESET_n = 1'b1;
        rom_ack = 1'b1;
        send(8'd1, 25'h0, 8'h99);
        vectors++;
        if ({mod_id, rom_wr} !== {8'h99, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_first_edge: got mod=%h wr=%b expected 99 0", mod_id, rom_wr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({rom_wr, ioctl_wait, byte_count} !== {2'b00, 25'd0}) begin
                miscompares++;
                $display("FAIL rst_no_late_wr[%0d]: got wr=%b wait=%b cnt=%0d expected 0 0 0",
                         i, rom_wr, ioctl_wait, byte_count);
            end
        end
        rom_ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_rom_zero_wait();
        test_rom_stall();
        test_rom_range();
        test_flush();
        test_dip_mod();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arcade_ioctl_router.md
ARCADE_IOCTL_ROUTER -- requirements
Module: arcade_ioctl_router

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_REGIONS, 4, ROM regions, 1..8
- ADDR_W, 25, ioctl address width
- REGION_BASE, {0,'h10000,'h20000,'h30000}, ascending byte base per region, packed NUM_REGIONS*ADDR_W
- ROM_SIZE, 'h40000, first invalid ROM byte address
- DIP_BYTES, 8, DIP bytes captured
- ROM_INDEX / MOD_INDEX / DIP_INDEX, 0 / 1 / 254, ioctl_index values
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_sys, in, 1, sole clock
- RESET_n, in, 1, asynchronous active-low reset
- ioctl_download, in, 1, HPS transfer active
- ioctl_index, in, 8, transfer type
- ioctl_wr, in, 1, byte strobe
- ioctl_addr, in, ADDR_W, byte address
- ioctl_dout, in, 8, byte data
- ioctl_wait, out, 1, stall to HPS
- rom_wr, out, 1, write request to region target
- rom_sel, out, $clog2(NUM_REGIONS) (min 1), region number
- rom_addr, out, ADDR_W, address relative to region base
- rom_data, out, 8, write data
- rom_ack, in, 1, target accepted write
- dip, out, DIP_BYTES*8, captured DIP bytes, byte n at [8n+7:8n]
- mod_id, out, 8, last captured MOD byte
- rom_loaded, out, 1, a complete ROM download has finished
- done_pulse, out, 1, one-cycle end-of-ROM-download strobe
- byte_count, out, ADDR_W, ROM bytes accepted this download
- err_range, out, 1, sticky ROM address >= ROM_SIZE
- err_ovf, out, 1, sticky ioctl_wr received while busy

Function
REQ-003 FSM states: IDLE, REQ, FLUSH. Reset state IDLE.
REQ-004 IDLE, ioctl_wr & ioctl_download & index==ROM_INDEX & addr<ROM_SIZE: register sel/addr/data; rom_wr=1 and ioctl_wait=1 on the next cycle; go to REQ.
REQ-005 Region select: highest r with REGION_BASE[r] <= addr. Output rom_addr = addr - REGION_BASE[r], ADDR_W-bit unsigned.
REQ-006 REQ: rom_wr, rom_sel, rom_addr and rom_data held stable until rom_ack=1 is sampled. On that edge: rom_wr=0, ioctl_wait=0, byte_count+1, next state IDLE. rom_ack is ignored outside REQ.
REQ-007 Zero-wait target (rom_ack tied high): one ROM byte per 2 cycles; ioctl_wait high for exactly 1 cycle per byte.
REQ-008 ROM write with addr >= ROM_SIZE: no rom_wr issued; err_range set; byte_count unchanged.
REQ-009 ioctl_wr in REQ or FLUSH: byte dropped; err_ovf set; in-flight request unaffected.
REQ-010 ioctl_wr, index==DIP_INDEX, addr<DIP_BYTES: dip byte[addr]=ioctl_dout on the next edge; no wait. Higher addresses are ignored.
REQ-011 ioctl_wr, index==MOD_INDEX: mod_id=ioctl_dout, last write wins; no wait.
REQ-012 DIP and MOD capture operate in any FSM state.
REQ-013 Falling edge of ioctl_download during a ROM transfer, state IDLE: done_pulse=1 for one cycle; rom_loaded=1.
REQ-014 Same falling edge while in REQ: go to FLUSH. FLUSH completes the pending write on rom_ack, then done_pulse, then IDLE.
REQ-015 Rising edge of ioctl_download with index==ROM_INDEX: byte_count=0, err_range=0, err_ovf=0, rom_loaded=0.
REQ-016 Other indices never touch rom_*, byte_count or rom_loaded.
REQ-017 byte_count saturates at all-ones.

Reset
REQ-018 RESET_n low forces all of the following asynchronously and aborts any in-flight request without a late rom_wr:
- state IDLE
- rom_wr, ioctl_wait, done_pulse, rom_loaded, err_range, err_ovf all 0
- byte_count 0, rom_sel/rom_addr/rom_data 0
- dip all-ones (switches open)
- mod_id 0
REQ-019 After reset release, first capture is possible on the first rising edge with RESET_n high.

Structure
REQ-020 Shared package arcade_ioctl_pkg holds:
- FSM state enum
- default index constants ROM/MOD/DIP
- default REGION_BASE
REQ-021 One sub-module, ioctl_region_decode: combinational priority decode of region and relative address, reused by other cores.

Verification
REQ-022 Bench shall cover these directed scenarios:
- ROM write addr='h10005, data='hA5, rom_ack tied 1 -> rom_sel=1, rom_addr=5, rom_data='hA5, ioctl_wait high 1 cycle, byte_count=1.
- rom_ack held low 5 cycles -> rom_wr and ioctl_wait high 6 cycles, outputs stable; second ioctl_wr in the window -> err_ovf=1, first write unaffected.
- DIP index 254, addrs 0..9 with data 'h10+addr -> dip bytes 0..7 = 'h10..'h17; addrs 8,9 ignored; MOD write 'h01 -> mod_id=1.
- ROM addr=ROM_SIZE -> no rom_wr, err_range=1; new ROM download start -> err_range=0.
- ioctl_download falls while in REQ, ack after 3 cycles -> done_pulse 1 cycle after ack, rom_loaded=1.
- RESET_n low mid-REQ -> rom_wr=0 and ioctl_wait=0 immediately, dip='hFF each byte, no rom_wr after release.
